// File: rtl/ddr2_idelay_pkg.sv
// Shared types and constants for the IDELAYCTRL reset/readiness sequencer.
// Default parameter values and the clk200 timing facts the sequencer must honour.
package ddr2_idelay_pkg;

    typedef enum logic [2:0] {
        RST_ASSERT,
        WAIT_RDY,
        STABLE,
        READY,
        FAIL
    } seq_state_e;

    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_RDY_TIMEOUT   = 4096;
    localparam int DEF_STABLE_CYCLES = 8;
    localparam int DEF_MAX_RETRY     = 3;
    localparam int DEF_RETRY_W       = 2;

    localparam int CLK200_PERIOD_PS  = 5000;

    // IDELAYCTRL needs a 50 ns reset pulse; at 200 MHz that is 10 cycles.
    localparam int MIN_RST_PULSE_PS  = 50000;
    localparam int MIN_RST_CYCLES    = MIN_RST_PULSE_PS / CLK200_PERIOD_PS;

    // Bits needed to count 0..terminal-1, never narrower than one bit.
    function automatic int cnt_w(input int terminal);
        return (terminal > 1) ? $clog2(terminal) : 1;
    endfunction

endpackage

// File: rtl/ddr2_idelay_rst_seq_if.sv
// Control/status bundle between the sequencer, the IDELAYCTRL wrapper and
// the DDR2 controller init logic.
interface ddr2_idelay_rst_seq_if #(
    parameter int RETRY_W = 2
);
    logic               recal_req;
    logic               rdy_status;
    logic               idelay_rst;
    logic               idelay_ready;
    logic               calib_fail;
    logic [RETRY_W-1:0] retry_cnt;

    modport master (
        input  recal_req,
        input  rdy_status,
        output idelay_rst,
        output idelay_ready,
        output calib_fail,
        output retry_cnt
    );

    modport slave (
        output recal_req,
        output rdy_status,
        input  idelay_rst,
        input  idelay_ready,
        input  calib_fail,
        input  retry_cnt
    );
endinterface

// File: rtl/ddr2_sync2.sv
// Generic two-flop synchronizer for a single asynchronous level.
// Reset forces both stages low so the output starts deasserted.
module ddr2_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    // NOTE: sequential state uses non-blocking assignments so both stages
    // sample on the same edge and form a true two-stage shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/ddr2_idelay_rst_seq.sv
// Reset pulse generator and ready qualifier for the IDELAYCTRL bank wrapper,
// with timeout-driven retries and a sticky failure report.
module ddr2_idelay_rst_seq
    import ddr2_idelay_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int RDY_TIMEOUT   = DEF_RDY_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRY     = DEF_MAX_RETRY,
    parameter int RETRY_W       = DEF_RETRY_W
) (
    input  logic                  clk200,
    input  logic                  reset,
    ddr2_idelay_rst_seq_if.master bus
);

    localparam int RST_W = cnt_w(RST_CYCLES);
    localparam int TMO_W = cnt_w(RDY_TIMEOUT);
    localparam int STB_W = cnt_w(STABLE_CYCLES);

    localparam logic [RST_W-1:0]   RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(RDY_TIMEOUT - 1);
    localparam logic [STB_W-1:0]   STB_LAST  = STB_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    seq_state_e         state_q, state_d;
    logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [STB_W-1:0]   stb_cnt_q, stb_cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;

    logic idelay_rst_q, idelay_ready_q, calib_fail_q;
    logic rdy_s;
    logic timeout_hit;
    logic timeout_take;
    logic [TMO_W-1:0] tmo_cnt_inc;

    ddr2_sync2 u_rdy_sync (
        .clk (clk200),
        .rst (reset),
        .d   (bus.rdy_status),
        .q   (rdy_s)
    );

    // The attempt timer saturates at its terminal value so that an entry into
    // STABLE on the last WAIT_RDY cycle still times out instead of wrapping.
    assign timeout_hit = (tmo_cnt_q == TMO_LAST);
    assign tmo_cnt_inc = timeout_hit ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);

    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        stb_cnt_d    = stb_cnt_q;
        retry_d      = retry_q;
        timeout_take = 1'b0;

        unique case (state_q)
            RST_ASSERT: begin
                rst_cnt_d = rst_cnt_q + RST_W'(1);
                if (rst_cnt_q == RST_LAST) begin
                    state_d   = WAIT_RDY;
                    rst_cnt_d = '0;
                    tmo_cnt_d = '0;
                end
            end

            WAIT_RDY: begin
                tmo_cnt_d = tmo_cnt_inc;
                if (rdy_s) begin
                    state_d   = STABLE;
                    stb_cnt_d = STB_W'(1);
                end else if (timeout_hit) begin
                    timeout_take = 1'b1;
                end
            end

            STABLE: begin
                tmo_cnt_d = tmo_cnt_inc;
                if (rdy_s && stb_cnt_q == STB_LAST) begin
                    state_d = READY;
                    retry_d = '0;
                end else if (timeout_hit) begin
                    timeout_take = 1'b1;
                end else if (rdy_s) begin
                    stb_cnt_d = stb_cnt_q + STB_W'(1);
                end else begin
                    state_d   = WAIT_RDY;
                    stb_cnt_d = '0;
                end
            end

            READY: begin
                // Loss of lock and a recalibration request share one exit.
                if (!rdy_s || bus.recal_req) begin
                    state_d   = RST_ASSERT;
                    rst_cnt_d = '0;
                end
            end

            FAIL: begin
                if (bus.recal_req) begin
                    state_d   = RST_ASSERT;
                    rst_cnt_d = '0;
                    retry_d   = '0;
                end
            end

            default: begin
                state_d   = RST_ASSERT;
                rst_cnt_d = '0;
            end
        endcase

        if (timeout_take) begin
            if (retry_q == RETRY_MAX) begin
                state_d = FAIL;
            end else begin
                state_d   = RST_ASSERT;
                rst_cnt_d = '0;
                retry_d   = retry_q + RETRY_W'(1);
            end
        end
    end

    always_ff @(posedge clk200 or posedge reset) begin
        if (reset) begin
            state_q   <= RST_ASSERT;
            rst_cnt_q <= '0;
            tmo_cnt_q <= '0;
            stb_cnt_q <= '0;
            retry_q   <= '0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            stb_cnt_q <= stb_cnt_d;
            retry_q   <= retry_d;
        end
    end

    // Outputs are flops loaded from the next-state decode, so they track the
    // state register exactly while staying glitch-free toward the wrapper.
    always_ff @(posedge clk200 or posedge reset) begin
        if (reset) begin
            idelay_rst_q   <= 1'b1;
            idelay_ready_q <= 1'b0;
            calib_fail_q   <= 1'b0;
        end else begin
            idelay_rst_q   <= (state_d == RST_ASSERT);
            idelay_ready_q <= (state_d == READY);
            calib_fail_q   <= (state_d == FAIL);
        end
    end

    assign bus.idelay_rst   = idelay_rst_q;
    assign bus.idelay_ready = idelay_ready_q;
    assign bus.calib_fail   = calib_fail_q;
    assign bus.retry_cnt    = retry_q;

endmodule

// File: tb/tb_ddr2_idelay_rst_seq.sv
// Scoreboard bench: stimulus queues the expected output changes with their
// clk200 edge numbers; a monitor compares every observed output change.
module tb_ddr2_idelay_rst_seq;
    import ddr2_idelay_pkg::*;

    typedef struct {
        string      name;
        int         cyc;
        bit         chk_cyc;
        logic [4:0] outs;   // {idelay_rst, idelay_ready, calib_fail, retry_cnt}
    } exp_t;

    logic clk200 = 1'b0;
    logic reset  = 1'b0;
    int   edge_n = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    exp_t exp_q[$];

    ddr2_idelay_rst_seq_if #(.RETRY_W(DEF_RETRY_W)) ifc ();

    ddr2_idelay_rst_seq #(
        .RST_CYCLES    (DEF_RST_CYCLES),
        .RDY_TIMEOUT   (DEF_RDY_TIMEOUT),
        .STABLE_CYCLES (DEF_STABLE_CYCLES),
        .MAX_RETRY     (DEF_MAX_RETRY),
        .RETRY_W       (DEF_RETRY_W)
    ) dut (
        .clk200 (clk200),
        .reset  (reset),
        .bus    (ifc)
    );

    always #5 clk200 = ~clk200;
    always @(posedge clk200) edge_n <= edge_n + 1;

    task automatic check(input string name, input bit ok, input string got, input string want);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %s, expected %s", name, got, want);
        end
    endtask

    task automatic push_ev(input string name, input int cyc, input bit chk,
                           input logic rst, input logic rdy, input logic fail,
                           input logic [1:0] retry);
        exp_t e;
        e.name    = name;
        e.cyc     = cyc;
        e.chk_cyc = chk;
        e.outs    = {rst, rdy, fail, retry};
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int n);
        while (edge_n < n) @(negedge clk200);
    endtask

    task automatic pulse_recal(input int at);
        wait_until(at);
        ifc.recal_req = 1'b1;
        wait_until(at + 1);
        ifc.recal_req = 1'b0;
    endtask

    task automatic drop_rdy(input int at);
        wait_until(at);
        ifc.rdy_status = 1'b0;
        wait_until(at + 1);
        ifc.rdy_status = 1'b1;
    endtask

    // Assert reset just after a rising edge; the outputs must move before the next one.
    task automatic hit_reset(input string name, input bit changes);
        @(posedge clk200);
        #1;
        if (changes) push_ev(name, edge_n, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk200);
    endtask

    task automatic release_reset(output int b);
        @(negedge clk200);
        reset = 1'b0;
        b     = edge_n;
    endtask

    // Monitor: every change of the output vector consumes one expectation.
    bit         first_smp = 1'b1;
    logic [4:0] last_outs;
    int         rst_len = 0;

    always @(negedge clk200) begin : monitor
        logic [4:0] cur;
        exp_t       e;
        cur = {ifc.idelay_rst, ifc.idelay_ready, ifc.calib_fail, ifc.retry_cnt};
        if (first_smp || cur !== last_outs) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_change: got outs=%b at edge %0d, expected no change", cur, edge_n);
            end else begin
                e = exp_q.pop_front();
                check(e.name, cur === e.outs && (!e.chk_cyc || e.cyc == edge_n),
                      $sformatf("outs=%b at edge %0d", cur, edge_n),
                      $sformatf("outs=%b at edge %0d", e.outs, e.cyc));
            end
            if (!first_smp && last_outs[4] === 1'b1 && cur[4] === 1'b0)
                check("min_rst_pulse", rst_len >= MIN_RST_CYCLES,
                      $sformatf("%0d cycles", rst_len), $sformatf(">= %0d cycles", MIN_RST_CYCLES));
            first_smp = 1'b0;
            last_outs = cur;
        end
        rst_len = (cur[4] === 1'b1) ? rst_len + 1 : 0;
    end

    initial begin
        int b, l, m, r;
        ifc.recal_req  = 1'b0;
        ifc.rdy_status = 1'b1;

        // Nominal bring-up; a recal pulse during RST_ASSERT must be ignored.
        push_ev("reset_state", 0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        #1 reset = 1'b1;
        repeat (3) @(negedge clk200);
        release_reset(b);
        push_ev("nom_rst_fall", b + 16, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        push_ev("nom_ready",    b + 24, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
        pulse_recal(b + 5);

        // Loss of lock for one cycle: ready drops three edges later.
        l = b + 30;
        push_ev("lol_drop",     l + 3,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        push_ev("lol_rst_fall", l + 19, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        push_ev("lol_ready",    l + 27, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
        drop_rdy(l);

        // Recal on the same edge as a synchronized drop: a single restart.
        l = l + 40;
        push_ev("both_drop",     l + 3,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        push_ev("both_rst_fall", l + 19, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        push_ev("both_ready",    l + 27, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
        drop_rdy(l);
        pulse_recal(l + 2);

        // Recal from READY, then an asynchronous reset while in STABLE.
        m = l + 35;
        push_ev("recal_rst",      m + 1,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        push_ev("recal_rst_fall", m + 17, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        pulse_recal(m);
        wait_until(m + 19);
        hit_reset("async_rst_stable", 1'b1);
        release_reset(b);
        push_ev("rerun_rst_fall", b + 16, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        push_ev("rerun_ready",    b + 24, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
        wait_until(b + 30);

        // Glitch: 5 high, 1 low, then steady high; the count restarts.
        ifc.rdy_status = 1'b0;
        hit_reset("glitch_reset", 1'b1);
        release_reset(b);
        push_ev("glitch_rst_fall", b + 16, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        push_ev("glitch_ready",    b + 36, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
        wait_until(b + 20);
        ifc.rdy_status = 1'b1;
        wait_until(b + 25);
        ifc.rdy_status = 1'b0;
        wait_until(b + 26);
        ifc.rdy_status = 1'b1;
        wait_until(b + 45);

        // Ready arrives during the second attempt.
        ifc.rdy_status = 1'b0;
        hit_reset("late_reset", 1'b1);
        release_reset(b);
        push_ev("late_rst_fall1", b + 16,   1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        push_ev("late_retry1",    b + 4112, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
        push_ev("late_rst_fall2", b + 4128, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
        push_ev("late_ready",     b + 4140, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
        wait_until(b + 4130);
        ifc.rdy_status = 1'b1;
        wait_until(b + 4150);

        // Never ready: four pulses, then FAIL; recal in WAIT_RDY is ignored.
        ifc.rdy_status = 1'b0;
        hit_reset("fail_reset", 1'b1);
        release_reset(b);
        for (int i = 0; i < 4; i++) begin
            push_ev($sformatf("fail_rst_fall%0d", i), b + 16 + 4112 * i, 1'b1,
                    1'b0, 1'b0, 1'b0, 2'(i));
            if (i < 3)
                push_ev($sformatf("fail_retry%0d", i + 1), b + 4112 * (i + 1), 1'b1,
                        1'b1, 1'b0, 1'b0, 2'(i + 1));
        end
        push_ev("fail_enter", b + 16448, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3);
        pulse_recal(b + 100);

        // Recal out of FAIL clears the failure and retry count.
        r = b + 16460;
        wait_until(r - 10);
        ifc.rdy_status = 1'b1;
        push_ev("fail_recal",     r + 1,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        push_ev("fail_rst_fall",  r + 17, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        push_ev("fail_ready",     r + 25, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
        pulse_recal(r);
        wait_until(r + 40);

        check("queue_drained", exp_q.size() == 0,
              $sformatf("%0d pending", exp_q.size()), "0 pending");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
